control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Single-cycle RISC-V (RV64I subset) instruction decoder for the datapath.
- Takes a 32-bit instruction and drives:
  - register-file address and write-enable signals
  - the sign-extended immediate
  - three datapath mux selects
  - the ALU operation code
  - the data-memory write enable
- All outputs are registered on the clock edge, so the decode is visible one cycle after the instruction is presented.

Parameters:
- WORDSIZE, 64, datapath word width; width of cu_immediate.
- INSTRUCTION_SIZE, 32, instruction width; fixed at 32 for RISC-V.

Ports:
- clk  input  1  clock; rising edge active.
- reset  input  1  synchronous, active-high reset.
- instruction  input  INSTRUCTION_SIZE  instruction to decode.
- cu_rf_addr_a  output  5  register-file read address A (rs1).
- cu_rf_addr_b  output  5  register-file read address B (rs2).
- cu_rf_write_addr  output  5  register-file write address (rd).
- cu_rf_write_en  output  1  register-file write enable.
- cu_immediate  output  WORDSIZE  sign-extended immediate.
- cu_mux_0_sel  output  1  ALU input A source: 0 = rf port A, 1 = constant zero.
- cu_mux_1_sel  output  1  ALU input B source: 0 = rf port B, 1 = cu_immediate.
- cu_mux_2_sel  output  1  rf write-data source: 0 = ALU result, 1 = data-memory read data.
- cu_alu_operation  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra.
- cu_dm_write_en  output  1  data-memory write enable.

Behaviour:
- Update rule: all outputs are registers updated on the rising edge of clk; latency is 1 cycle from instruction to outputs. No handshake; a new instruction is accepted every cycle.
- Reset: when reset=1 at an edge, every output becomes 0.
- Reset priority: reset has priority over decode.
- Field extraction (every opcode):
  - cu_rf_addr_a = instruction[19:15]
  - cu_rf_addr_b = instruction[24:20]
  - cu_rf_write_addr = instruction[11:7]
- Immediate formats, each sign-extended from its top bit to WORDSIZE:
  - I: instruction[31:20]
  - S: {instruction[31:25], instruction[11:7]}
  - U: {instruction[31:12], 12'b0}
- Opcode 0000011 (load, any funct3):
  - I imm
  - mux0=0, mux1=1, mux2=1, alu=000
  - rf_write_en=1, dm_write_en=0
- Opcode 0100011 (store):
  - S imm
  - mux0=0, mux1=1, mux2=0, alu=000
  - rf_write_en=0, dm_write_en=1
- Opcode 0110011 (R-type):
  - imm=0, mux0=0, mux1=0, mux2=0, rf_write_en=1, dm_write_en=0
  - ALU op from funct3/funct7[5]:
    - 000/0 add, 000/1 sub
    - 111 and, 110 or, 100 xor
    - 001 sll, 101/0 srl, 101/1 sra
  - Other funct3 values (slt, sltu): add.
- Opcode 0010011 (I-type ALU):
  - I imm, mux0=0, mux1=1, mux2=0, rf_write_en=1, dm_write_en=0
  - ALU op from funct3 as for R-type, except funct3 000 is always add.
  - For funct3 101, funct7[5] selects sra.
- Opcode 0110111 (lui):
  - U imm, mux0=1, mux1=1, mux2=0, alu=000
  - rf_write_en=1, dm_write_en=0
- Any other opcode:
  - rf_write_en=0, dm_write_en=0
  - imm=0, all mux selects 0, alu=000
  - Address fields still extracted.
- rd = x0: cu_rf_write_en is still driven per opcode; the register file ignores writes to x0.
- Instruction changes between edges have no effect until the next edge.

Test Plan:
- Reset: assert reset for one edge with any instruction -> all outputs 0, including write enables and immediate.
- Load 0x06B3_8183 (imm 0x06B, rs1 7, rd 3), one edge:
  - cu_rf_addr_a=7, cu_rf_write_addr=3
  - cu_immediate=107, mux0=0, mux1=1, mux2=1
  - alu=000, rf_write_en=1, dm_write_en=0
- Store, funct7-field 1011011, rs2 7, rs1 19, funct3 000, imm-low 00011, opcode 0100011:
  - addr_a=19, addr_b=7
  - cu_immediate=0xFFFF_FFFF_FFFF_FB63, mux1=1
  - rf_write_en=0, dm_write_en=1
- Add: funct7 0, rs2 7, rs1 19, rd 3 ->
  - addr_a=19, addr_b=7, write_addr=3
  - mux0=0, mux1=0, mux2=0, alu=000
  - rf_write_en=1, dm_write_en=0
- Sub: funct7 0100000, rs2 31, rs1 25, rd 6 ->
  - addr_a=25, addr_b=31, write_addr=6
  - alu=001, rf_write_en=1
- Latency check: change instruction mid-cycle from add to sub -> outputs stay add-decode until the next rising edge, then show sub. Illegal opcode 0000000 -> both write enables 0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: registered RV64I-subset instruction decoder driving register file, immediate, muxes, ALU and data memory
module control_unit #(
  parameter int WORDSIZE = 64,
  parameter int INSTRUCTION_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [4:0]                  cu_rf_addr_a,
  output logic [4:0]                  cu_rf_addr_b,
  output logic [4:0]                  cu_rf_write_addr,
  output logic                        cu_rf_write_en,
  output logic [WORDSIZE-1:0]         cu_immediate,
  output logic                        cu_mux_0_sel,
  output logic                        cu_mux_1_sel,
  output logic                        cu_mux_2_sel,
  output logic [2:0]                  cu_alu_operation,
  output logic                        cu_dm_write_en
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7_b5;
  logic is_load, is_store, is_r, is_i, is_lui;
  logic [WORDSIZE-1:0] imm_i, imm_s, imm_u, imm_d;
  logic [2:0] alu_op, alu_d;
  logic m0_d, m1_d, m2_d, rf_we_d, dm_we_d;
  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign funct7_b5 = instruction[30];
  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_r      = opcode == OP_R;
  assign is_i      = opcode == OP_I;
  assign is_lui    = opcode == OP_LUI;
  assign imm_i = {{(WORDSIZE-12){instruction[31]}}, instruction[31:20]};
  assign imm_s = {{(WORDSIZE-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_u = {{(WORDSIZE-32){instruction[31]}}, instruction[31:12], 12'b0};
  // Combinational decode; funct7[5] only turns add into sub for R-type, while it selects sra for both
  always_comb begin
    alu_op = funct3 == 3'b000 ? {2'b00, is_r & funct7_b5} :
             funct3 == 3'b111 ? 3'b010 :
             funct3 == 3'b110 ? 3'b011 :
             funct3 == 3'b100 ? 3'b100 :
             funct3 == 3'b001 ? 3'b101 :
             funct3 == 3'b101 ? {2'b11, funct7_b5} : 3'b000;
    alu_d   = (is_r | is_i) ? alu_op : 3'b000;
    imm_d   = (is_load | is_i) ? imm_i : is_store ? imm_s : is_lui ? imm_u : '0;
    m0_d    = is_lui;
    m1_d    = is_load | is_store | is_i | is_lui;
    m2_d    = is_load;
    rf_we_d = is_load | is_r | is_i | is_lui;
    dm_we_d = is_store;
  end
  // Register every output; reset clears all of them and wins over decode
  always_ff @(posedge clk) begin
    if (reset) begin
      cu_rf_addr_a     <= '0;
      cu_rf_addr_b     <= '0;
      cu_rf_write_addr <= '0;
      cu_rf_write_en   <= 1'b0;
      cu_immediate     <= '0;
      cu_mux_0_sel     <= 1'b0;
      cu_mux_1_sel     <= 1'b0;
      cu_mux_2_sel     <= 1'b0;
      cu_alu_operation <= '0;
      cu_dm_write_en   <= 1'b0;
    end else begin
      cu_rf_addr_a     <= instruction[19:15];
      cu_rf_addr_b     <= instruction[24:20];
      cu_rf_write_addr <= instruction[11:7];
      cu_rf_write_en   <= rf_we_d;
      cu_immediate     <= imm_d;
      cu_mux_0_sel     <= m0_d;
      cu_mux_1_sel     <= m1_d;
      cu_mux_2_sel     <= m2_d;
      cu_alu_operation <= alu_d;
      cu_dm_write_en   <= dm_we_d;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for the registered instruction decoder
module tb_control_unit;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] instruction;
  logic [4:0] cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr;
  logic cu_rf_write_en, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_dm_write_en;
  logic [63:0] cu_immediate;
  logic [2:0] cu_alu_operation;
  logic [7:0] ctl;
  logic [14:0] addrs;
  int n_checks = 0;
  int n_fail = 0;
  control_unit #(.WORDSIZE(64), .INSTRUCTION_SIZE(32)) dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .cu_rf_addr_a(cu_rf_addr_a),
    .cu_rf_addr_b(cu_rf_addr_b),
    .cu_rf_write_addr(cu_rf_write_addr),
    .cu_rf_write_en(cu_rf_write_en),
    .cu_immediate(cu_immediate),
    .cu_mux_0_sel(cu_mux_0_sel),
    .cu_mux_1_sel(cu_mux_1_sel),
    .cu_mux_2_sel(cu_mux_2_sel),
    .cu_alu_operation(cu_alu_operation),
    .cu_dm_write_en(cu_dm_write_en)
  );
  always #5 clk = ~clk;
  // control bundle: {mux0, mux1, mux2, alu[2:0], rf_we, dm_we}; address bundle: {rs1, rs2, rd}
  assign ctl = {cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation, cu_rf_write_en, cu_dm_write_en};
  assign addrs = {cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    instruction = 32'h06B3_8183;
    step();
    n_checks++;
    if (ctl !== 8'h00) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, 8'h00); end
    n_checks++;
    if (addrs !== 15'd0) begin n_fail++; $display("FAIL reset_addrs got %h want %h", addrs, 15'd0); end
    n_checks++;
    if (cu_immediate !== 64'd0) begin n_fail++; $display("FAIL reset_imm got %h want %h", cu_immediate, 64'd0); end
    reset = 1'b0;
  endtask
  task automatic test_load();
    instruction = 32'h06B3_8183;
    step();
    n_checks++;
    if (addrs !== {5'd7, 5'd11, 5'd3}) begin n_fail++; $display("FAIL load_addrs got %h want %h", addrs, {5'd7, 5'd11, 5'd3}); end
    n_checks++;
    if (cu_immediate !== 64'd107) begin n_fail++; $display("FAIL load_imm got %h want %h", cu_immediate, 64'd107); end
    n_checks++;
    if (ctl !== 8'b0_1_1_000_1_0) begin n_fail++; $display("FAIL load_ctl got %b want %b", ctl, 8'b0_1_1_000_1_0); end
  endtask
  task automatic test_store();
    instruction = {7'b1011011, 5'd7, 5'd19, 3'b000, 5'b00011, 7'b0100011};
    step();
    n_checks++;
    if ({cu_rf_addr_a, cu_rf_addr_b} !== {5'd19, 5'd7}) begin n_fail++; $display("FAIL store_addrs got %d/%d want 19/7", cu_rf_addr_a, cu_rf_addr_b); end
    n_checks++;
    if (cu_immediate !== 64'hFFFF_FFFF_FFFF_FB63) begin n_fail++; $display("FAIL store_imm got %h want %h", cu_immediate, 64'hFFFF_FFFF_FFFF_FB63); end
    n_checks++;
    if (ctl !== 8'b0_1_0_000_0_1) begin n_fail++; $display("FAIL store_ctl got %b want %b", ctl, 8'b0_1_0_000_0_1); end
  endtask
  task automatic test_rtype();
    logic [2:0] f3 [9] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b101, 3'b010};
    logic [6:0] f7 [9] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
    logic [2:0] exp_alu [9] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
    instruction = {7'h00, 5'd7, 5'd19, 3'b000, 5'd3, 7'b0110011};
    step();
    n_checks++;
    if (addrs !== {5'd19, 5'd7, 5'd3}) begin n_fail++; $display("FAIL add_addrs got %h want %h", addrs, {5'd19, 5'd7, 5'd3}); end
    n_checks++;
    if (ctl !== 8'b0_0_0_000_1_0) begin n_fail++; $display("FAIL add_ctl got %b want %b", ctl, 8'b0_0_0_000_1_0); end
    n_checks++;
    if (cu_immediate !== 64'd0) begin n_fail++; $display("FAIL add_imm got %h want 0", cu_immediate); end
    instruction = {7'b0100000, 5'd31, 5'd25, 3'b000, 5'd6, 7'b0110011};
    step();
    n_checks++;
    if (addrs !== {5'd25, 5'd31, 5'd6}) begin n_fail++; $display("FAIL sub_addrs got %h want %h", addrs, {5'd25, 5'd31, 5'd6}); end
    n_checks++;
    if (ctl !== 8'b0_0_0_001_1_0) begin n_fail++; $display("FAIL sub_ctl got %b want %b", ctl, 8'b0_0_0_001_1_0); end
    for (int i = 0; i < 9; i++) begin
      instruction = {f7[i], 5'd2, 5'd1, f3[i], 5'd4, 7'b0110011};
      step();
      n_checks++;
      if (ctl !== {3'b000, exp_alu[i], 2'b10}) begin n_fail++; $display("FAIL rtype_%0d got %b want %b", i, ctl, {3'b000, exp_alu[i], 2'b10}); end
    end
  endtask
  task automatic test_itype();
    logic [11:0] imm [4] = '{12'h400, 12'h405, 12'hFFF, 12'h005};
    logic [2:0] f3 [4] = '{3'b000, 3'b101, 3'b111, 3'b101};
    logic [2:0] exp_alu [4] = '{3'b000, 3'b111, 3'b010, 3'b110};
    logic [63:0] exp_imm [4] = '{64'd1024, 64'd1029, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    for (int i = 0; i < 4; i++) begin
      instruction = {imm[i], 5'd9, f3[i], 5'd10, 7'b0010011};
      step();
      n_checks++;
      if (ctl !== {3'b010, exp_alu[i], 2'b10}) begin n_fail++; $display("FAIL itype_ctl_%0d got %b want %b", i, ctl, {3'b010, exp_alu[i], 2'b10}); end
      n_checks++;
      if (cu_immediate !== exp_imm[i]) begin n_fail++; $display("FAIL itype_imm_%0d got %h want %h", i, cu_immediate, exp_imm[i]); end
    end
  endtask
  task automatic test_lui();
    instruction = {20'h80001, 5'd5, 7'b0110111};
    step();
    n_checks++;
    if (ctl !== 8'b1_1_0_000_1_0) begin n_fail++; $display("FAIL lui_ctl got %b want %b", ctl, 8'b1_1_0_000_1_0); end
    n_checks++;
    if (cu_immediate !== 64'hFFFF_FFFF_8000_1000) begin n_fail++; $display("FAIL lui_imm got %h want %h", cu_immediate, 64'hFFFF_FFFF_8000_1000); end
    n_checks++;
    if (cu_rf_write_addr !== 5'd5) begin n_fail++; $display("FAIL lui_rd got %d want 5", cu_rf_write_addr); end
  endtask
  task automatic test_illegal();
    instruction = {12'hABC, 5'd17, 3'b010, 5'd21, 7'b0000000};
    step();
    n_checks++;
    if (ctl !== 8'h00) begin n_fail++; $display("FAIL illegal_ctl got %b want %b", ctl, 8'h00); end
    n_checks++;
    if (cu_immediate !== 64'd0) begin n_fail++; $display("FAIL illegal_imm got %h want 0", cu_immediate); end
    n_checks++;
    if (addrs !== {5'd17, 5'h1C, 5'd21}) begin n_fail++; $display("FAIL illegal_addrs got %h want %h", addrs, {5'd17, 5'h1C, 5'd21}); end
  endtask
  task automatic test_latency();
    instruction = {7'h00, 5'd7, 5'd19, 3'b000, 5'd3, 7'b0110011};
    step();
    #3;
    instruction = {7'b0100000, 5'd31, 5'd25, 3'b000, 5'd6, 7'b0110011};
    #1;
    n_checks++;
    if (ctl !== 8'b0_0_0_000_1_0 || addrs !== {5'd19, 5'd7, 5'd3}) begin n_fail++; $display("FAIL latency_hold got %b/%h want %b/%h", ctl, addrs, 8'b0_0_0_000_1_0, {5'd19, 5'd7, 5'd3}); end
    step();
    n_checks++;
    if (ctl !== 8'b0_0_0_001_1_0 || addrs !== {5'd25, 5'd31, 5'd6}) begin n_fail++; $display("FAIL latency_update got %b/%h want %b/%h", ctl, addrs, 8'b0_0_0_001_1_0, {5'd25, 5'd31, 5'd6}); end
  endtask
  task automatic test_reset_priority();
    reset = 1'b1;
    instruction = {7'b1011011, 5'd7, 5'd19, 3'b000, 5'b00011, 7'b0100011};
    step();
    n_checks++;
    if (ctl !== 8'h00 || cu_immediate !== 64'd0 || addrs !== 15'd0) begin n_fail++; $display("FAIL reset_priority got %b/%h/%h want all zero", ctl, cu_immediate, addrs); end
    reset = 1'b0;
    step();
    n_checks++;
    if (ctl !== 8'b0_1_0_000_0_1) begin n_fail++; $display("FAIL after_reset_ctl got %b want %b", ctl, 8'b0_1_0_000_0_1); end
  endtask
  initial begin
    reset = 1'b1;
    instruction = '0;
    test_reset();
    test_load();
    test_store();
    test_rtype();
    test_itype();
    test_lui();
    test_illegal();
    test_latency();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
